// File: rtl/twi_pkg.sv
// rtl/twi_pkg.sv - shared TWI target state encoding, bus constants and address helper
package twi_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_WAIT_END  = 4'd9;

  // Bit counter value seen at the rising edge of the last (8th) bit of a byte
  localparam logic [2:0] C_BIT_LAST = 3'd7;

  localparam logic C_SDA_PULL    = 1'b0;
  localparam logic C_SDA_RELEASE = 1'b1;

  function automatic logic twi_addr_hit(input logic [7:0] rx_byte, input logic [6:0] slv_addr);
    return (rx_byte[7:1] == slv_addr);
  endfunction

endpackage

// File: rtl/twi_slv_filter.sv
// rtl/twi_slv_filter.sv - SCL/SDA synchronizers with SCL edge and START/STOP detection
module twi_slv_filter (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic SCL_I,
  input  logic SDA_I,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;
  logic       w_scl;
  logic       w_sda;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], SCL_I};
      r_sda_sync <= {r_sda_sync[0], SDA_I};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
    end
  end

  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_hist;
  assign o_scl_fall = ~w_scl & r_scl_hist;
  // SCL must be high on both sides of the SDA edge to qualify as START/STOP
  assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
  assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

endmodule

// File: rtl/twi_slave.sv
// rtl/twi_slave.sv - TWI register-file target (non-stretching, CLK_I >= 16x SCL)
// Define TWI_SLV_AUTOINC_EN to advance the pointer after every written or read byte.
module twi_slave
  import twi_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         REG_NUM  = 8
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic                       SCL_I,
  input  logic                       SDA_I,
  output logic                       SDA_OEN,
  input  logic [$clog2(REG_NUM)-1:0] LOC_ADR_I,
  output logic [7:0]                 LOC_DAT_O,
  output logic                       WR_STB_O,
  output logic [$clog2(REG_NUM)-1:0] WR_ADR_O,
  output logic [7:0]                 WR_DAT_O,
  output logic                       BUSY_O
);

  localparam int AW = $clog2(REG_NUM);

  logic          w_sda;
  logic          w_scl_rise;
  logic          w_scl_fall;
  logic          w_start;
  logic          w_stop;
  logic [7:0]    w_byte;
  logic [7:0]    w_rd_byte;
  logic [AW-1:0] w_ptr_next;

  logic [3:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic [AW-1:0] r_ptr;
  logic          r_byte_done;
  logic          r_rw;
  logic          r_mack;
  logic          r_sda_oen;
  logic          r_wr_stb;
  logic [AW-1:0] r_wr_adr;
  logic [7:0]    r_wr_dat;
  logic          r_busy;
  logic [7:0]    r_regs [REG_NUM];

  twi_slv_filter u_filter (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .SCL_I      (SCL_I),
    .SDA_I      (SDA_I),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // Byte as it will look once the current SCL rising-edge bit is shifted in
  assign w_byte    = {r_shift, w_sda};
  assign w_rd_byte = r_regs[r_ptr];

`ifdef TWI_SLV_AUTOINC_EN
  assign w_ptr_next = r_ptr + AW'(1);
`else
  assign w_ptr_next = r_ptr;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_ptr       <= '0;
      r_byte_done <= 1'b0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_sda_oen   <= C_SDA_RELEASE;
      r_wr_stb    <= 1'b0;
      r_wr_adr    <= '0;
      r_wr_dat    <= 8'h00;
      r_busy      <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= 8'h00;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop) begin
        r_state     <= ST_IDLE;
        r_sda_oen   <= C_SDA_RELEASE;
        r_busy      <= 1'b0;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
      end else if (w_start) begin
        r_state     <= ST_ADDR;
        r_sda_oen   <= C_SDA_RELEASE;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == C_BIT_LAST) begin
                r_rw <= w_sda;
                if (twi_addr_hit(w_byte, SLV_ADDR)) begin
                  r_byte_done <= 1'b1;
                end else begin
                  r_state <= ST_WAIT_END;
                  r_busy  <= 1'b0;
                end
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              r_state     <= ST_ADDR_ACK;
              r_sda_oen   <= C_SDA_PULL;
              r_busy      <= 1'b1;
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_state   <= ST_RDATA;
                r_shift   <= w_rd_byte[6:0];
                r_sda_oen <= w_rd_byte[7];
              end else begin
                r_state   <= ST_PTR;
                r_sda_oen <= C_SDA_RELEASE;
              end
            end
          end
          ST_PTR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == C_BIT_LAST) begin
                r_ptr       <= w_byte[AW-1:0];
                r_byte_done <= 1'b1;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              r_state     <= ST_PTR_ACK;
              r_sda_oen   <= C_SDA_PULL;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_state   <= ST_WDATA;
              r_sda_oen <= C_SDA_RELEASE;
            end
          end
          ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == C_BIT_LAST) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_stb      <= 1'b1;
                r_wr_adr      <= r_ptr;
                r_wr_dat      <= w_byte;
                r_ptr         <= w_ptr_next;
                r_byte_done   <= 1'b1;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              r_state     <= ST_WDATA_ACK;
              r_sda_oen   <= C_SDA_PULL;
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == C_BIT_LAST) begin
                r_byte_done <= 1'b1;
                r_ptr       <= w_ptr_next;
              end
            end else if (w_scl_fall) begin
              if (r_byte_done) begin
                r_byte_done <= 1'b0;
                r_state     <= ST_RDATA_ACK;
                r_sda_oen   <= C_SDA_RELEASE;
              end else begin
                r_shift   <= {r_shift[5:0], 1'b0};
                r_sda_oen <= r_shift[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda;
            end else if (w_scl_fall) begin
              if (!r_mack) begin
                r_state   <= ST_RDATA;
                r_shift   <= w_rd_byte[6:0];
                r_sda_oen <= w_rd_byte[7];
              end else begin
                r_state <= ST_WAIT_END;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDA_OEN   = r_sda_oen;
  assign LOC_DAT_O = r_regs[LOC_ADR_I];
  assign WR_STB_O  = r_wr_stb;
  assign WR_ADR_O  = r_wr_adr;
  assign WR_DAT_O  = r_wr_dat;
  assign BUSY_O    = r_busy;

endmodule

// File: tb/tb_twi_slave.sv
// tb/tb_twi_slave.sv - bus-master bench for twi_slave with a register-file reference model
module tb_twi_slave;

  localparam int REG_NUM = 8;
  localparam int AW      = 3;
  localparam int Q       = 50;
`ifdef TWI_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b1;
  logic          SCL_I;
  logic          SDA_I;
  logic          SDA_OEN;
  logic [AW-1:0] LOC_ADR_I = '0;
  logic [7:0]    LOC_DAT_O;
  logic          WR_STB_O;
  logic [AW-1:0] WR_ADR_O;
  logic [7:0]    WR_DAT_O;
  logic          BUSY_O;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  assign SCL_I = scl_m;
  assign SDA_I = sda_m & SDA_OEN;

  twi_slave #(.SLV_ADDR(7'h50), .REG_NUM(REG_NUM)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .SCL_I(SCL_I), .SDA_I(SDA_I), .SDA_OEN(SDA_OEN),
    .LOC_ADR_I(LOC_ADR_I), .LOC_DAT_O(LOC_DAT_O), .WR_STB_O(WR_STB_O),
    .WR_ADR_O(WR_ADR_O), .WR_DAT_O(WR_DAT_O), .BUSY_O(BUSY_O)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_fail   = 0;
  int acks;

  logic [7:0] mem [REG_NUM];
  int         mptr;
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];
  logic [7:0] rexp [4];
  int         exp_adr_q [$];
  logic [7:0] exp_dat_q [$];
  int         stb_adr_q [$];
  logic [7:0] stb_dat_q [$];
  bit         busy_seen;
  bit         oen_low_seen;

  typedef struct {
    logic [7:0] abyte;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nd;
    int         exp_acks;
    int         exp_stb;
  } wvec_t;
  wvec_t tv [6];

  always @(negedge CLK_I) begin
    if (WR_STB_O) begin
      stb_adr_q.push_back(int'(WR_ADR_O));
      stb_dat_q.push_back(WR_DAT_O);
    end
    if (BUSY_O) busy_seen = 1'b1;
    if (!SDA_OEN) oen_low_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: byte-level register file semantics
  task automatic model_reset();
    for (int i = 0; i < REG_NUM; i++) mem[i] = 8'h00;
    mptr = 0;
    exp_adr_q.delete();
    exp_dat_q.delete();
  endtask

  task automatic model_write(input logic [7:0] abyte, input logic [7:0] p, input int nd);
    if (abyte[7:1] == 7'h50 && !abyte[0]) begin
      mptr = int'(p) % REG_NUM;
      for (int i = 0; i < nd; i++) begin
        mem[mptr] = wbuf[i];
        exp_adr_q.push_back(mptr);
        exp_dat_q.push_back(wbuf[i]);
        if (AUTOINC) mptr = (mptr + 1) % REG_NUM;
      end
    end
  endtask

  task automatic model_read(input int n);
    for (int i = 0; i < n; i++) begin
      rexp[i] = mem[mptr];
      if (AUTOINC) mptr = (mptr + 1) % REG_NUM;
    end
  endtask

  // Bus master primitives
  task automatic bit_w(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic bit_r(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = SDA_I; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_start();
    @(negedge CLK_I);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(a);
    ack = ~a;
  endtask

  task automatic byte_r(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(nack);
  endtask

  task automatic bus_write(input logic [7:0] abyte, input logic [7:0] p, input int nd);
    logic a;
    bus_start();
    byte_w(abyte, a);
    acks += int'(a);
    if (a) begin
      byte_w(p, a);
      acks += int'(a);
      for (int i = 0; i < nd; i++) begin
        byte_w(wbuf[i], a);
        acks += int'(a);
      end
    end
    bus_stop();
  endtask

  task automatic bus_read(input logic [7:0] abyte, input int n);
    logic a;
    bus_start();
    byte_w(abyte, a);
    acks += int'(a);
    if (a) begin
      for (int i = 0; i < n; i++) byte_r(i == n - 1, rbuf[i]);
    end
    bus_stop();
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < REG_NUM; a++) begin
      @(negedge CLK_I);
      LOC_ADR_I = AW'(a);
      #1;
      chk($sformatf("%s_reg%0d", tag, a), LOC_DAT_O, mem[a]);
    end
  endtask

  task automatic check_stb(input string tag);
    int n;
    chk({tag, "_stb_count"}, stb_adr_q.size(), exp_adr_q.size());
    n = (stb_adr_q.size() < exp_adr_q.size()) ? stb_adr_q.size() : exp_adr_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_stb%0d_adr", tag, i), stb_adr_q[i], exp_adr_q[i]);
      chk($sformatf("%s_stb%0d_dat", tag, i), stb_dat_q[i], exp_dat_q[i]);
    end
    stb_adr_q.delete(); stb_dat_q.delete();
    exp_adr_q.delete(); exp_dat_q.delete();
  endtask

  task automatic check_reads(input string tag, input int n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_rd%0d", tag, i), rbuf[i], rexp[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    int nr;
    logic [7:0] p;
    logic [7:0] ab;
    logic a;

    model_reset();
    repeat (4) @(negedge CLK_I);
    chk("reset_sda_oen", SDA_OEN, 1'b1);
    chk("reset_wr_stb", WR_STB_O, 1'b0);
    chk("reset_busy", BUSY_O, 1'b0);
    RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    check_mem("reset");

    tv[0] = '{8'hA0, 8'h00, 8'h11, 8'h22, 2, 4, 2};
    tv[1] = '{8'hA2, 8'h01, 8'h77, 8'h00, 1, 0, 0};
    tv[2] = '{8'hA0, 8'h07, 8'hC3, 8'h3C, 2, 4, 2};
    tv[3] = '{8'hA0, 8'h0D, 8'h99, 8'h00, 1, 3, 1};
    tv[4] = '{8'hA4, 8'h02, 8'h55, 8'h00, 1, 0, 0};
    tv[5] = '{8'hA0, 8'h02, 8'hE7, 8'h00, 1, 3, 1};
    for (int i = 0; i < 6; i++) begin
      wbuf[0] = tv[i].d0;
      wbuf[1] = tv[i].d1;
      acks = 0;
      busy_seen = 1'b0;
      oen_low_seen = 1'b0;
      bus_write(tv[i].abyte, tv[i].ptr, tv[i].nd);
      model_write(tv[i].abyte, tv[i].ptr, tv[i].nd);
      chk($sformatf("tv%0d_acks", i), acks, tv[i].exp_acks);
      chk($sformatf("tv%0d_stbs", i), stb_adr_q.size(), tv[i].exp_stb);
      chk($sformatf("tv%0d_busy_seen", i), busy_seen, tv[i].exp_acks != 0);
      chk($sformatf("tv%0d_sda_pulled", i), oen_low_seen, tv[i].exp_acks != 0);
      repeat (4) @(negedge CLK_I);
      chk($sformatf("tv%0d_busy_after_stop", i), BUSY_O, 1'b0);
      check_stb($sformatf("tv%0d", i));
      check_mem($sformatf("tv%0d", i));
    end

    // Pointer 3, two data bytes
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    acks = 0;
    bus_write(8'hA0, 8'h03, 2);
    model_write(8'hA0, 8'h03, 2);
    chk("w34_acks", acks, 4);
    check_stb("w34");
    check_mem("w34");

    // Set pointer to 7 then read two bytes across the wrap
    acks = 0;
    bus_write(8'hA0, 8'h07, 0);
    model_write(8'hA0, 8'h07, 0);
    bus_read(8'hA1, 2);
    model_read(2);
    chk("wrap_acks", acks, 3);
    check_reads("wrap", 2);

    // Foreign address is ignored entirely
    wbuf[0] = 8'h77;
    acks = 0;
    busy_seen = 1'b0;
    oen_low_seen = 1'b0;
    bus_write(8'hA2, 8'h01, 1);
    chk("foreign_acks", acks, 0);
    chk("foreign_sda_pulled", oen_low_seen, 1'b0);
    chk("foreign_busy", busy_seen, 1'b0);
    check_stb("foreign");

    // Repeated START after 4 bits of a data byte discards the partial byte
    acks = 0;
    bus_start();
    byte_w(8'hA0, a); acks += int'(a);
    byte_w(8'h06, a); acks += int'(a);
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1);
    model_write(8'hA0, 8'h06, 0);
    bus_read(8'hA1, 1);
    model_read(1);
    chk("rstart_acks", acks, 3);
    check_reads("rstart", 1);
    check_stb("rstart");
    check_mem("rstart");

    // Reset pulsed in the middle of a read byte; bus activity ignored until next START
    wbuf[0] = 8'h00;
    bus_write(8'hA0, 8'h01, 1);
    model_write(8'hA0, 8'h01, 1);
    check_stb("pre_rst");
    acks = 0;
    bus_start();
    byte_w(8'hA1, a); acks += int'(a);
    chk("midrst_addr_ack", acks, 1);
    for (int i = 0; i < 5; i++) bit_r(a);
    chk("midrst_driving", SDA_OEN, 1'b0);
    RST_I = 1'b1;
    #1;
    chk("midrst_sda_released", SDA_OEN, 1'b1);
    chk("midrst_busy", BUSY_O, 1'b0);
    oen_low_seen = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b0;
    for (int i = 0; i < 3; i++) bit_r(a);
    chk("postrst_quiet", oen_low_seen, 1'b0);
    bus_stop();
    wbuf[0] = 8'hA5;
    acks = 0;
    bus_write(8'hA0, 8'h05, 1);
    model_write(8'hA0, 8'h05, 1);
    chk("postrst_acks", acks, 3);
    check_stb("postrst");
    check_mem("postrst");

    // Two bytes at pointer 2: with a holding pointer reg[3] keeps its value
    wbuf[0] = 8'h5C;
    acks = 0;
    bus_write(8'hA0, 8'h03, 1);
    model_write(8'hA0, 8'h03, 1);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    bus_write(8'hA0, 8'h02, 2);
    model_write(8'hA0, 8'h02, 2);
    chk("hold_acks", acks, 7);
    check_stb("hold");
    check_mem("hold");

    for (int it = 0; it < 8; it++) begin
      p  = 8'($urandom_range(0, 15));
      nd = $urandom_range(1, 3);
      ab = ($urandom_range(0, 4) == 0) ? 8'hA6 : 8'hA0;
      for (int i = 0; i < nd; i++) wbuf[i] = 8'($urandom_range(0, 255));
      acks = 0;
      bus_write(ab, p, nd);
      model_write(ab, p, nd);
      chk($sformatf("rnd%0d_wacks", it), acks, (ab == 8'hA0) ? nd + 2 : 0);
      check_stb($sformatf("rnd%0d", it));
      nr = $urandom_range(1, 3);
      acks = 0;
      bus_read(8'hA1, nr);
      model_read(nr);
      chk($sformatf("rnd%0d_racks", it), acks, 1);
      check_reads($sformatf("rnd%0d", it), nr);
    end
    check_mem("rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/twi_slave.md
TWI_SLAVE -- requirements
Module: twi_slave

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h50, the 7-bit bus address this target answers.
REQ-002 SHALL have parameter REG_NUM, default 8, the register-file depth in bytes (power of 2).
REQ-003 SHALL have port CLK_I, input, 1 bit, system clock.
REQ-004 SHALL have port RST_I, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port SCL_I, input, 1 bit, bus clock from the TWI master (asynchronous).
REQ-006 SHALL have port SDA_I, input, 1 bit, bus data (asynchronous).
REQ-007 SHALL have port SDA_OEN, output, 1 bit: 0 = pull SDA low, 1 = release.
REQ-008 SHALL have ports LOC_ADR_I, input, log2(REG_NUM) bits; LOC_DAT_O, output, 8 bits. Together they form a combinational local read of reg[LOC_ADR_I].
REQ-009 SHALL have ports WR_STB_O, output, 1 bit; WR_ADR_O, output, log2(REG_NUM) bits; WR_DAT_O, output, 8 bits. Together they give a one-cycle strobe for each byte written by the bus.
REQ-010 SHALL have port BUSY_O, output, 1 bit, high from an addressed START until STOP.

Function
REQ-011 SCL_I and SDA_I SHALL pass through 2-FF synchronizers plus one history FF, and all edge detection SHALL use synchronized values.
REQ-012 START detection SHALL be: synchronized SDA falls while SCL is high. STOP detection SHALL be: SDA rises while SCL is high. Both SHALL be honoured in every state.
REQ-013 The state machine SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_END.
REQ-014 START (including a repeated START) SHALL force ADDR and clear the bit counter.
REQ-015 STOP SHALL force IDLE and set SDA_OEN=1 in the same cycle.
REQ-016 SDA SHALL be sampled on the SCL rising edge, MSB first. A 3-bit counter SHALL count 8 bits per byte.
REQ-017 SDA_OEN SHALL change only on an SCL falling edge, within 1 CLK_I after that edge is detected.
REQ-018 In ADDR, if the address matches SLV_ADDR, the state SHALL go to ADDR_ACK and drive ACK (SDA_OEN=0) for one SCL period. R/W=0 SHALL then go to PTR; R/W=1 SHALL go to RDATA.
REQ-019 In ADDR, an address mismatch SHALL go to WAIT_END with SDA released until the next START or STOP.
REQ-020 In PTR, the low log2(REG_NUM) bits of the received byte SHALL load the pointer. The state SHALL then ACK and go to WDATA.
REQ-021 In WDATA, each byte SHALL be written to reg[ptr] at the 8th rising edge, WR_STB_O SHALL pulse for 1 CLK_I, and the state SHALL then ACK. Every data byte SHALL be ACKed.
REQ-022 In RDATA, reg[ptr] SHALL be loaded into the shift register at the SCL falling edge that ends ADDR_ACK or RDATA_ACK, and each bit SHALL be driven on the following falling edges.
REQ-023 In RDATA_ACK, a master ACK (SDA=0) SHALL continue with the next byte. A master NACK SHALL go to WAIT_END with SDA released.
REQ-024 The pointer SHALL wrap modulo REG_NUM.
REQ-025 The target SHALL NOT stretch SCL, and CLK_I SHALL be at least 16× the SCL rate.
REQ-026 A bus write and a local read of the same address in the same cycle SHALL return the old value on LOC_DAT_O.
REQ-027 A START occurring mid-byte SHALL discard the partial byte, and no WR_STB_O SHALL be issued for it.

Reset
REQ-028 On RST_I: state=IDLE, SDA_OEN=1, WR_STB_O=0, BUSY_O=0, ptr=0, bit counter=0, shift register=0, all register-file bytes=8'h00, synchronizers=1.
REQ-029 RST_I asserted mid-transfer SHALL release SDA immediately (asynchronously). After RST_I deasserts, the block SHALL ignore the bus until the next START.

Configuration
REQ-030 With macro TWI_SLV_AUTOINC_EN defined, ptr SHALL increment after each write byte and after each read byte.
REQ-031 With TWI_SLV_AUTOINC_EN undefined, ptr SHALL hold, so repeated bytes write or read the same register.

Structure
REQ-032 The state encoding and the START/STOP/bit-count constants SHALL live in shared package twi_pkg, used alongside twi_define.v.
REQ-033 Synchronization and START/STOP/edge detection SHALL be sub-module twi_slv_filter. The state machine, shift register and register file SHALL stay in twi_slave.

Verification
REQ-034 Write 0xA0, 0x03, 0x5A, 0xC3, then STOP: four ACKs; reg[3]=0x5A, reg[4]=0xC3 (AUTOINC); WR_STB_O pulses twice with WR_ADR_O 3 then 4.
REQ-035 Write 0xA0, 0x07, STOP; then START, 0xA1, read two bytes, ACK then NACK: returns reg[7] then reg[0] (wrap).
REQ-036 Address 0xA2 (mismatch): no ACK (SDA_OEN stays 1), no WR_STB_O, BUSY_O=0.
REQ-037 Repeated START after 4 bits of a data byte, then 0xA1: the partial byte is discarded and the read returns reg[ptr] unchanged.
REQ-038 RST_I pulsed during RDATA bit 5: SDA_OEN=1 within the same cycle; a following normal write succeeds.
REQ-039 With TWI_SLV_AUTOINC_EN undefined, write 0xA0, 0x02, 0x11, 0x22: reg[2]=0x22 and reg[3] is unchanged.
